// File: rtl/proc_pkg.sv
// Shared definitions for the fetch path: instruction field positions,
// the NOP opcode and the fetch-request FSM state encoding.
package proc_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS_HI  = 7;
    localparam int RS_LO  = 4;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [3:0] OPC_NOP = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_HALT = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_req_fsm.sv
// Fetch-request controller: owns the IDLE/PEND/HALT state, raises the
// memory request on a fetch strobe when no word is held, and tracks
// whether the instruction register holds a usable word.
module fetch_req_fsm
    import proc_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic fetch_stb,
    input  logic exec_stb,
    input  logic incr_stb,
    input  logic mem_rvalid,
    input  logic dec_valid,
    input  logic halt,
    output logic mem_req,
    output logic ir_load,
    output logic ir_valid,
    output logic halted
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic         ir_valid_r;
    logic         ir_valid_nxt_s;
    logic         halt_hit_s;

    assign halt_hit_s = exec_stb & halt & dec_valid;

    // State and ir_valid registers; clr clears them at any time.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r    <= ST_IDLE;
            ir_valid_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ir_valid_r <= ir_valid_nxt_s;
        end
    end

    // Next state, request generation and ir_valid set/clear.
    always_comb begin
        state_nxt_s    = state_r;
        ir_valid_nxt_s = ir_valid_r;
        mem_req        = 1'b0;
        ir_load        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (halt_hit_s) begin
                    state_nxt_s = ST_HALT;
                end else if (fetch_stb && !ir_valid_r) begin
                    mem_req = 1'b1;
                    if (mem_rvalid) begin
                        ir_load        = 1'b1;
                        ir_valid_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_PEND;
                    end
                end else if (incr_stb && dec_valid) begin
                    ir_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                // A late word lands here; the slot it missed is already a bubble.
                if (halt_hit_s) begin
                    state_nxt_s = ST_HALT;
                end else if (mem_rvalid) begin
                    ir_load        = 1'b1;
                    ir_valid_nxt_s = 1'b1;
                    state_nxt_s    = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            ST_HALT: begin
                state_nxt_s = ST_HALT;
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                ir_valid_nxt_s = 1'b0;
            end
        endcase
    end

    assign ir_valid = ir_valid_r;
    assign halted   = (state_r == ST_HALT);

endmodule

// File: rtl/fetch_unit.sv
// Program counter, instruction register and field decode, stepped by
// the one-hot phase strobes f/d/e/i. A late memory word turns the slot
// into a bubble instead of stalling the sequencer.
module fetch_unit
    import proc_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               f,
    input  logic               d,
    input  logic               e,
    input  logic               i,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_rvalid,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ir,
    output logic               dec_valid,
    output logic [3:0]         opcode,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [7:0]         imm,
    output logic               halted
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic               incr_stb_s;
    logic               exec_stb_s;
    logic               decode_stb_s;
    logic               fetch_stb_s;
    logic               ir_load_s;
    logic               ir_valid_s;
    logic               halted_s;

    logic [ADDR_W-1:0]  pc_r;
    logic [INSTR_W-1:0] ir_r;
    logic [3:0]         opcode_r;
    logic [3:0]         rd_r;
    logic [3:0]         rs_r;
    logic [7:0]         imm_r;
    logic               dec_valid_r;
    logic               br_pend_r;
    logic [ADDR_W-1:0]  br_tgt_r;

    // Illegal multi-strobe cycles resolve as i > e > d > f.
    assign incr_stb_s   = i;
    assign exec_stb_s   = e & ~i;
    assign decode_stb_s = d & ~i & ~e;
    assign fetch_stb_s  = f & ~i & ~e & ~d;

    fetch_req_fsm u_req (
        .clk        (clk),
        .clr        (clr),
        .fetch_stb  (fetch_stb_s),
        .exec_stb   (exec_stb_s),
        .incr_stb   (incr_stb_s),
        .mem_rvalid (mem_rvalid),
        .dec_valid  (dec_valid_r),
        .halt       (halt),
        .mem_req    (mem_req),
        .ir_load    (ir_load_s),
        .ir_valid   (ir_valid_s),
        .halted     (halted_s)
    );

    // PC, IR, decoded fields and pending branch; everything freezes in HALT.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc_r        <= RESET_PC;
            ir_r        <= {INSTR_W{1'b0}};
            opcode_r    <= 4'h0;
            rd_r        <= 4'h0;
            rs_r        <= 4'h0;
            imm_r       <= 8'h00;
            dec_valid_r <= 1'b0;
            br_pend_r   <= 1'b0;
            br_tgt_r    <= {ADDR_W{1'b0}};
        end else if (!halted_s) begin
            if (ir_load_s) begin
                ir_r <= mem_rdata;
            end
            if (incr_stb_s) begin
                // Bubbles leave pc alone so a late word is decoded next round.
                if (dec_valid_r) begin
                    pc_r        <= br_pend_r ? br_tgt_r : (pc_r + PC_ONE);
                    br_pend_r   <= 1'b0;
                    dec_valid_r <= 1'b0;
                end
            end else if (exec_stb_s) begin
                if (dec_valid_r) begin
                    br_pend_r <= br_taken;
                    br_tgt_r  <= br_target;
                end
            end else if (decode_stb_s) begin
                if (ir_valid_s) begin
                    opcode_r    <= ir_r[OPC_HI:OPC_LO];
                    rd_r        <= ir_r[RD_HI:RD_LO];
                    rs_r        <= ir_r[RS_HI:RS_LO];
                    imm_r       <= ir_r[IMM_HI:IMM_LO];
                    dec_valid_r <= 1'b1;
                end else begin
                    opcode_r    <= OPC_NOP;
                    rd_r        <= 4'h0;
                    rs_r        <= 4'h0;
                    imm_r       <= 8'h00;
                    dec_valid_r <= 1'b0;
                end
            end
        end
    end

    assign mem_addr  = pc_r;
    assign pc        = pc_r;
    assign ir        = ir_r;
    assign opcode    = opcode_r;
    assign rd        = rd_r;
    assign rs        = rs_r;
    assign imm       = imm_r;
    assign dec_valid = dec_valid_r;
    assign halted    = halted_s;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter, instruction-register and field-decode block driven by the phase strobes of `seq_gen` (`f`, `d`, `e`, `i`).
- It issues the instruction-memory request during the fetch phase and captures the returned word.
- It registers the decoded fields during the decode phase and updates the PC during the increment phase.
- It sits directly downstream of `seq_gen` and upstream of the execute datapath.
- A memory response that arrives too late for the decode phase turns that instruction slot into a bubble; no stall feeds back to the sequencer.

## Interface
Parameters:
- `ADDR_W`, 8, PC and memory address width
- `INSTR_W`, 16, instruction width (field map fixed for 16)
- `RESET_PC`, 0, PC value loaded at reset

Ports:
- `clk`  in  1  system clock, rising edge
- `clr`  in  1  reset, asynchronous, active-low
- `f`, `d`, `e`, `i`  in  1 each  one-hot phase strobes from `seq_gen`, one cycle each
- `mem_req`  out  1  fetch request
- `mem_addr`  out  ADDR_W  fetch address, equals `pc`
- `mem_rdata`  in  INSTR_W  instruction word
- `mem_rvalid`  in  1  `mem_rdata` valid this cycle
- `br_taken`  in  1  branch decision from execute, sampled on `e`
- `br_target`  in  ADDR_W  branch target, sampled on `e`
- `halt`  in  1  halt request from execute, sampled on `e`
- `pc`  out  ADDR_W  current PC
- `ir`  out  INSTR_W  instruction register
- `dec_valid`  out  1  decoded fields hold a real instruction
- `opcode`  out  4  decoded field, `ir[15:12]`
- `rd`  out  4  decoded field, `ir[11:8]`
- `rs`  out  4  decoded field, `ir[7:4]`
- `imm`  out  8  decoded field, `ir[7:0]`
- `halted`  out  1  block is in HALT

## Operation
FSM states and transitions:
- IDLE
  - `f` with `ir_valid`=0 drives `mem_req`=1.
  - `mem_rvalid` in that same cycle loads `ir` and sets `ir_valid`; the state stays IDLE.
  - Otherwise the next state is PEND.
  - `f` with `ir_valid`=1 issues no request.
- PEND
  - `mem_req`=0.
  - The first `mem_rvalid` loads `ir`, sets `ir_valid` and returns to IDLE.
- HALT
  - Entered when `e` occurs with `halt`=1 and `dec_valid`=1.
  - No requests are issued and `pc`, `ir` and the decoded fields freeze.
  - Only `clr` exits HALT.

`mem_req` is combinational: `f & (state==IDLE) & ~ir_valid`. `mem_addr` always equals `pc`. `mem_rvalid` in IDLE without a same-cycle request, or in HALT, is ignored.

Phase actions:
- On `d`:
  - If `ir_valid`=1: register `opcode`/`rd`/`rs`/`imm` from `ir` and set `dec_valid`=1.
  - If `ir_valid`=0 (bubble): set `opcode`=NOP (4'h0), other fields to 0, `dec_valid`=0.
- On `e`: if `dec_valid`=1, latch `br_taken` and `br_target` into `br_pend`/`br_tgt`. If `dec_valid`=0, `br_taken` is ignored.
- On `i`:
  - If `dec_valid`=1: `pc` <= `br_pend` ? `br_tgt` : `pc`+1, computed modulo 2^ADDR_W so `pc` wraps from all-ones to 0. `ir_valid` clears, `br_pend` clears and `dec_valid` clears.
  - If `dec_valid`=0: `pc` holds and `ir_valid` is untouched, so a late word captured in PEND is decoded in the next round without being refetched.

Strobe conditions:
- Multiple strobes in one cycle are illegal. The RTL applies priority `i` > `e` > `d` > `f`, and the bench asserts one-hot.
- No strobe: all registers hold.

Reset:
- `clr`=0 at any time, including mid-PEND, forces the state to IDLE and clears every register.
- A response arriving after reset deasserts while the state is IDLE is ignored.

## Timing
Reset values:
- `pc`=RESET_PC.
- `ir`, `opcode`, `rd`, `rs`, `imm`, `br_pend`, `br_tgt`=0.
- `ir_valid`, `dec_valid`, `halted`, `mem_req`=0.
- State IDLE.

Latency, for `f` at cycle N with the sequencer running `f`,`d`,`e`,`i` back-to-back:
- Zero-wait memory (`mem_rvalid`=1 at N): `ir` is valid from N+1; `d` at N+1 samples it; fields and `dec_valid` are valid from N+2; `pc` updates at N+4.
- `mem_rvalid` at N+1 or later: the `d` at N+1 sees `ir_valid`=0 and produces a bubble, and `pc` holds at N+4.
- A response landing on the same edge as `d` is still a bubble. The `ir` load and the `d` sample share that edge, and `d` sees the old `ir_valid`.

Other cycle-level rules:
- `halted` rises the cycle after the qualifying `e`.
- `mem_req` can be high only during `f` cycles.

## Structure
Shared package `proc_pkg`:
- field-position constants: `OPC_HI`/`OPC_LO`, `RD_*`, `RS_*`, `IMM_*`
- `OPC_NOP`=4'h0
- the FSM state encoding IDLE/PEND/HALT

Sub-module `fetch_req_fsm`:
- contains the IDLE/PEND/HALT state register, `mem_req` generation and the `ir_valid` set/clear logic
- the top level holds the `pc`, `ir`, field and branch registers

## Test plan
- Reset and zero-wait fetch: `clr` low, then high, `RESET_PC`=0, `mem_rvalid`=1 during `f` with `rdata`=16'h3A5C -> `opcode`=3, `rd`=A, `rs`=5, `imm`=5C, `dec_valid`=1 at N+2, `pc`=1 after `i`.
- Late response: `rvalid` arrives 2 cycles after `f` with `rdata`=16'h1234 -> round 1 is a bubble with `opcode`=0, `dec_valid`=0, `pc` held at 0. In round 2 no `mem_req` is issued, 16'h1234 is decoded and `pc`=1 after `i`.
- Branch: `br_taken`=1, `br_target`=8'h40 at `e` of a valid instruction -> `pc`=8'h40 after `i`. `br_taken`=1 during a bubble -> `pc` unchanged.
- Wrap: `pc`=8'hFF with a valid instruction and no branch -> `pc`=8'h00 after `i`.
- Halt and reset mid-PEND:
  - `halt`=1 at `e` -> `halted`=1 the next cycle, no `mem_req` on later `f`, `pc` frozen.
  - Separately, drop `clr` while in PEND, then deliver `rvalid` after release -> `ir` stays 0, state IDLE, `pc`=RESET_PC.
